rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter AW, default 13, memory address width; depth 2**AW bytes (8192).
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle pulse; begins a load session.
REQ-005 abort  in  1  one-cycle pulse; terminates a session in progress.
REQ-006 len  in  14  bytes to load, sampled when start is accepted.
REQ-007 din  in  8  stream byte.
REQ-008 din_valid  in  1  din carries a byte.
REQ-009 din_ready  out  1  loader accepts din this cycle.
REQ-010 a  in  14  CPU read address; only a[AW-1:0] decoded.
REQ-011 dout  out  8  registered CPU read data.
REQ-012 busy  out  1  session in progress.
REQ-013 done  out  1  last session completed all bytes.
REQ-014 count  out  14  bytes written in current/last session.
REQ-015 checksum  out  8  modulo-256 sum of bytes written in current/last session.

Function
REQ-016 FSM states IDLE, LOAD, DONE; busy=1 only in LOAD, done=1 only in DONE.
REQ-017 IDLE/DONE + start, len!=0: -> LOAD; count<=0, checksum<=0; effective length = min(len, 8192).
REQ-018 IDLE/DONE + start, len==0: -> DONE; count<=0, checksum<=0; no writes.
REQ-019 start while in LOAD ignored.
REQ-020 din_ready = 1 iff state is LOAD (combinational from state); never 1 in IDLE/DONE.
REQ-021 Transfer = din_valid & din_ready; on transfer: mem[count[AW-1:0]]<=din, count<=count+1, checksum<=checksum+din (8-bit wrap).
REQ-022 Transfer of byte number effective-length: state -> DONE next edge; din_ready low in cycle after.
REQ-023 din_valid low in LOAD: no write, no change; no timeout.
REQ-024 abort in LOAD: -> IDLE next edge, no write that cycle even if din_valid=1; count/checksum hold; written bytes retained.
REQ-025 abort and start same cycle: abort wins in LOAD; start wins in IDLE/DONE (abort is no-op there).
REQ-026 Read: dout <= mem[a[AW-1:0]] every edge; one-cycle latency; a[13] ignored.
REQ-027 Read and write to same address same edge: dout returns old contents (read-before-write).
REQ-028 Memory content is not initialised or cleared by the block, nor by reset.
REQ-029 count saturates at 8192 only via effective length; never wraps within a session.

Reset
REQ-030 rst=1 at edge: state IDLE, busy=0, done=0, count=0, checksum=0, dout=0x00.
REQ-031 rst during LOAD: session discarded, no write at that edge; memory keeps already written bytes.
REQ-032 rst has priority over start, abort and transfers.

Structure
REQ-033 Shared package holds: state enumeration (IDLE, LOAD, DONE), AW default 13, MAX_LEN 8192.
REQ-034 Sub-module rom_loader_ram: 2**AW x 8 single-clock RAM, one write port (we, wa, wd), one registered read port; inferred block RAM, no reset on array.
REQ-035 FSM, counters and checksum live in rom_loader top; no further sub-modules.

Verification
REQ-036 rst; start len=4; stream 0x11,0x22,0x33,0x44 valid every cycle -> 4 transfers, done=1 cycle after last, count=4, checksum=0xAA; reads a=0..3 return those bytes one cycle later.
REQ-037 start len=3, din_valid toggling 1,0,1,0,1 -> exactly 3 writes, count=3, no write on valid-low cycles, din_ready=1 throughout LOAD.
REQ-038 start len=0 -> DONE next edge, count=0, checksum=0, din_ready never 1; start len=0x3FFF -> stops at count=8192.
REQ-039 start len=8, abort after 2 transfers with din_valid=1 -> IDLE, count=2, third byte not written, done=0.
REQ-040 a=0x2005 and write to 0x0005 same edge (old 0x00, new 0x5A) -> dout=0x00, next read of 0x0005 -> 0x5A.
REQ-041 rst pulse mid-load after 5 bytes -> IDLE, count=0, checksum=0, dout=0x00; bytes 0..4 still readable.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// Shared types and sizing for the streaming ROM loader.
package rom_loader_pkg;

  localparam int unsigned DEF_AW  = 13;
  localparam int unsigned MAX_LEN = 8192;
  localparam int unsigned LEN_W   = 14;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Requested lengths beyond the memory depth load the whole memory once.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : l;
  endfunction

endpackage

// File: rtl/rom_loader_ram.sv
// Single-clock byte RAM: one write port, one registered read port (read-before-write).
module rom_loader_ram
  import rom_loader_pkg::*;
#(
  parameter int unsigned AW = DEF_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     ra,
  output logic [DATA_W-1:0] rd
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
    end else begin
      rd <= mem[ra];
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Streams a byte sequence into a CPU-readable RAM, tracking count and checksum.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned AW = DEF_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [LEN_W-1:0]  a,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  count,
  output logic [DATA_W-1:0] checksum
);

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  eff_len;
  logic [LEN_W-1:0]  eff_len_nxt;
  logic [LEN_W-1:0]  count_nxt;
  logic [DATA_W-1:0] checksum_nxt;
  logic              we;
  logic              unused_a;

  assign din_ready = (state == ST_LOAD);
  // Upper address bits alias onto the same memory.
  assign unused_a  = ^a[LEN_W-1:AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      eff_len  <= '0;
      count    <= '0;
      checksum <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      eff_len  <= eff_len_nxt;
      count    <= count_nxt;
      checksum <= checksum_nxt;
      busy     <= (state_nxt == ST_LOAD);
      done     <= (state_nxt == ST_DONE);
    end
  end

  // Abort outranks start and transfers while loading; start is taken only when idle or done.
  always_comb begin
    state_nxt    = state;
    eff_len_nxt  = eff_len;
    count_nxt    = count;
    checksum_nxt = checksum;
    we           = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          count_nxt    = '0;
          checksum_nxt = '0;
          eff_len_nxt  = clamp_len(len);
          state_nxt    = (len == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (din_valid) begin
          we           = 1'b1;
          count_nxt    = count + LEN_W'(1);
          checksum_nxt = checksum + din;
          if (count_nxt == eff_len) begin
            state_nxt = ST_DONE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (rst) begin
      we = 1'b0;
    end
  end

  rom_loader_ram #(
    .AW (AW)
  ) u_ram (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .wa  (count[AW-1:0]),
    .wd  (din),
    .ra  (a[AW-1:0]),
    .rd  (dout)
  );

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed sessions, read scoreboard against a byte model.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [13:0] len = '0;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [13:0] a = '0;
  logic [7:0]  dout;
  logic        busy;
  logic        done;
  logic [13:0] count;
  logic [7:0]  checksum;

  always #5 clk = ~clk;

  rom_loader #(.AW(13)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .len       (len),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .a         (a),
    .dout      (dout),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .checksum  (checksum)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] model_mem [8192];
  logic [7:0] exp_q [$];
  logic [7:0] csum = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock; when rd is set, the byte at the current address is queued and checked after the edge.
  task automatic cycle(input bit rd);
    if (rd) exp_q.push_back(model_mem[a[12:0]]);
    tick();
    if (rd) check("dout", 32'(dout), 32'(exp_q.pop_front()));
  endtask

  task automatic read(input logic [13:0] addr);
    a = addr;
    cycle(1'b1);
  endtask

  task automatic begin_session(input logic [13:0] l);
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    csum  = '0;
  endtask

  task automatic xfer(input logic [7:0] b, input int idx, input bit rd);
    din_valid = 1'b1;
    din       = b;
    check("din_ready_load", 32'(din_ready), 32'd1);
    cycle(rd);
    model_mem[13'(idx)] = b;
    csum = csum + b;
  endtask

  task automatic check_status(input string tag, input bit exp_busy, input bit exp_done,
                              input logic [13:0] exp_cnt, input logic [7:0] exp_sum);
    check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_ready"}, 32'(din_ready), 32'(exp_busy));
    check({tag, "_count"}, 32'(count), 32'(exp_cnt));
    check({tag, "_checksum"}, 32'(checksum), 32'(exp_sum));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b1 [4];
    logic [7:0] b2 [3];
    int k;
    b1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    b2 = '{8'hA1, 8'hB2, 8'hC3};

    // Reset state
    tick();
    check_status("reset", 1'b0, 1'b0, 14'd0, 8'h00);
    check("reset_dout", 32'(dout), 32'h0);
    rst = 1'b0;

    // Basic four-byte load; a start mid-load must be ignored
    begin_session(14'd4);
    check_status("s1_start", 1'b1, 1'b0, 14'd0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        start = 1'b1;
        len   = 14'd1;
      end
      xfer(b1[i], i, 1'b0);
      start = 1'b0;
      check("s1_busy_mid", 32'(busy), 32'(i < 3));
    end
    din_valid = 1'b0;
    check_status("s1_end", 1'b0, 1'b1, 14'd4, 8'hAA);
    check("s1_csum_model", 32'(checksum), 32'(csum));
    for (int i = 0; i < 4; i++) read(14'(i));
    read(14'h2001);

    // Gapped stream: valid-low cycles write nothing
    begin_session(14'd3);
    k = 0;
    for (int c = 0; c < 5; c++) begin
      if (c % 2 == 0) begin
        xfer(b2[k], k, 1'b0);
        k++;
      end else begin
        din_valid = 1'b0;
        din       = 8'hEE;
        check("s2_ready_gap", 32'(din_ready), 32'd1);
        cycle(1'b0);
      end
      check("s2_count", 32'(count), 32'(k));
    end
    din_valid = 1'b0;
    check_status("s2_end", 1'b0, 1'b1, 14'd3, csum);
    for (int i = 0; i < 4; i++) read(14'(i));

    // Zero-length session
    begin_session(14'd0);
    check_status("s3_zero", 1'b0, 1'b1, 14'd0, 8'h00);
    din_valid = 1'b1;
    din       = 8'h99;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0);
      check_status("s3_zero_hold", 1'b0, 1'b1, 14'd0, 8'h00);
    end
    din_valid = 1'b0;

    // Oversized request clamps to full memory depth
    begin_session(14'h3FFF);
    for (int i = 0; i < 8192; i++) xfer(8'(i) ^ 8'h5C, i, 1'b0);
    check_status("s3_full", 1'b0, 1'b1, 14'd8192, csum);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0);
      check("s3_full_hold_count", 32'(count), 32'd8192);
    end
    din_valid = 1'b0;
    read(14'd0);
    read(14'd8191);
    read(14'h3FFF);

    // Same-edge read and write of one location returns old data
    begin_session(14'd6);
    for (int i = 0; i < 6; i++) xfer(8'h00, i, 1'b0);
    din_valid = 1'b0;
    begin_session(14'd6);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) a = 14'h2005;
      xfer((i == 5) ? 8'h5A : 8'(i + 1), i, i == 5);
    end
    din_valid = 1'b0;
    check("s4_old_data", 32'(dout), 32'h00);
    check("s4_done", 32'(done), 32'd1);
    read(14'h0005);

    // Abort after two transfers, with start and valid asserted alongside
    begin_session(14'd8);
    xfer(8'h61, 0, 1'b0);
    xfer(8'h62, 1, 1'b0);
    din_valid = 1'b1;
    din       = 8'h63;
    abort     = 1'b1;
    start     = 1'b1;
    len       = 14'd5;
    cycle(1'b0);
    abort     = 1'b0;
    start     = 1'b0;
    din_valid = 1'b0;
    check_status("s5_abort", 1'b0, 1'b0, 14'd2, 8'hC3);
    read(14'd2);
    // In idle, start beats a simultaneous abort
    len   = 14'd2;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    csum  = '0;
    check_status("s5_restart", 1'b1, 1'b0, 14'd0, 8'h00);
    xfer(8'h0A, 0, 1'b0);
    xfer(8'h0B, 1, 1'b0);
    din_valid = 1'b0;
    check_status("s5_restart_end", 1'b0, 1'b1, 14'd2, 8'h15);

    // Reset mid-load keeps already written bytes
    begin_session(14'd10);
    for (int i = 0; i < 5; i++) xfer(8'h71 + 8'(i), i, 1'b0);
    din_valid = 1'b1;
    din       = 8'hFF;
    a         = 14'd0;
    rst       = 1'b1;
    cycle(1'b0);
    rst       = 1'b0;
    din_valid = 1'b0;
    check_status("s6_rst", 1'b0, 1'b0, 14'd0, 8'h00);
    check("s6_rst_dout", 32'(dout), 32'h0);
    for (int i = 0; i < 6; i++) read(14'(i));

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
